data_bus_arbiter: RTL and testbench

Parametrised N-master to 1-slave arbiter for the SoC data bus (req/gnt address phase, rvalid/err/rdata response phase). Round-robin arbitration of the address phase; an in-order tracking FIFO routes each slave response back to the issuing master, allowing up to MAX_OUTST pipelined transactions. Sits between the CPU/DMA data ports and a shared memory or peripheral slave.

---
 rtl/data_bus_arbiter_pkg.sv | 30 +++
 rtl/data_bus_arbiter_if.sv | 39 +++
 rtl/data_bus_arbiter_id_fifo.sv | 49 ++++
 rtl/data_bus_arbiter.sv | 83 ++++++++
 tb/tb_data_bus_arbiter.sv | 244 ++++++++++++++++++++++++
 5 files changed

// File: rtl/data_bus_arbiter_pkg.sv
// Shared types and helpers for the N-master data bus arbiter.
// rr_pick is pure combinational round-robin selection; no timing of its own.
package data_bus_pkg;

   localparam int MAX_M     = 32;
   localparam int MAX_M_W   = 5;
   localparam int DEF_NUM_M = 2;
   localparam int DEF_ID_W  = (DEF_NUM_M > 1) ? $clog2(DEF_NUM_M) : 1;

   typedef logic [DEF_ID_W-1:0] mid_t;

   // First requester at or after ptr, wrapping modulo n; returns ptr when nobody asks.
   function automatic int unsigned rr_pick(input logic [MAX_M-1:0] req,
                                           input int unsigned       ptr,
                                           input int unsigned       n);
      int unsigned idx;
      logic        found;
      rr_pick = ptr;
      found   = 1'b0;
      for (int unsigned k = 0; k < MAX_M; k++) begin
         idx = ptr + k;
         if (idx >= n) idx = idx - n;
         if (k < n && !found && req[idx[MAX_M_W-1:0]]) begin
            rr_pick = idx;
            found   = 1'b1;
         end
      end
   endfunction

endpackage

// File: rtl/data_bus_arbiter_if.sv
// Master-side and slave-side bus signals of the arbiter; arb modport is the arbiter's view.
// Combinational req/gnt address phase, rvalid/err/rdata response phase.
interface data_bus_arbiter_if #(
   parameter  int NUM_M  = 2,
   parameter  int ADDR_W = 32,
   parameter  int DATA_W = 32,
   localparam int BE_W   = DATA_W / 8
);
   logic [NUM_M-1:0]        m_req;
   logic [NUM_M*ADDR_W-1:0] m_addr;
   logic [NUM_M-1:0]        m_we;
   logic [NUM_M*BE_W-1:0]   m_be;
   logic [NUM_M*DATA_W-1:0] m_wdata;
   logic [NUM_M-1:0]        m_gnt;
   logic [NUM_M-1:0]        m_rvalid;
   logic [NUM_M-1:0]        m_err;
   logic [DATA_W-1:0]       m_rdata;

   logic                    s_req;
   logic [ADDR_W-1:0]       s_addr;
   logic                    s_we;
   logic [BE_W-1:0]         s_be;
   logic [DATA_W-1:0]       s_wdata;
   logic                    s_gnt;
   logic                    s_rvalid;
   logic                    s_err;
   logic [DATA_W-1:0]       s_rdata;

   modport master (output m_req, m_addr, m_we, m_be, m_wdata,
                   input  m_gnt, m_rvalid, m_err, m_rdata);

   modport slave  (input  s_req, s_addr, s_we, s_be, s_wdata,
                   output s_gnt, s_rvalid, s_err, s_rdata);

   modport arb    (input  m_req, m_addr, m_we, m_be, m_wdata,
                   output m_gnt, m_rvalid, m_err, m_rdata,
                   output s_req, s_addr, s_we, s_be, s_wdata,
                   input  s_gnt, s_rvalid, s_err, s_rdata);
endinterface

// File: rtl/data_bus_arbiter_id_fifo.sv
// In-order FIFO of granted master ids; head visible combinationally, one-cycle push/pop.
// No internal backpressure: caller must not push when full nor pop when empty.
module data_bus_id_fifo #(
   parameter  int DEPTH = 4,
   parameter  int W     = 1,
   localparam int CNT_W = $clog2(DEPTH + 1),
   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [W-1:0]     din,
   input  logic             pop,
   output logic [W-1:0]     head,
   output logic [CNT_W-1:0] count,
   output logic             full,
   output logic             empty
);
   logic [W-1:0]     mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr, rd_ptr;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= din;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= ptr_inc(wr_ptr);
         if (pop)  rd_ptr <= ptr_inc(rd_ptr);
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   assign head  = mem[rd_ptr];
   assign full  = (count == CNT_W'(DEPTH));
   assign empty = (count == '0);
endmodule

// File: rtl/data_bus_arbiter.sv
// Round-robin N:1 data bus arbiter, zero added latency on both phases; responses routed in order.
// Slave backpressure via s_gnt; requests withheld while MAX_OUTST transactions are outstanding.
module data_bus_arbiter
   import data_bus_pkg::*;
#(
   parameter  int NUM_M     = 2,
   parameter  int ADDR_W    = 32,
   parameter  int DATA_W    = 32,
   parameter  int MAX_OUTST = 4,
   localparam int BE_W      = DATA_W / 8,
   localparam int CNT_W     = $clog2(MAX_OUTST + 1)
) (
   input  logic              clk,
   input  logic              rst,
   data_bus_arbiter_if.arb   bus,
   output logic [CNT_W-1:0]  outstanding,
   output logic              proto_err
);
   localparam int ID_W = (NUM_M > 1) ? $clog2(NUM_M) : 1;

   logic [ID_W-1:0]  ptr, sel, head;
   logic [MAX_M-1:0] req_ext;
   logic             full, empty, hs, pop;

   always_comb begin
      req_ext              = '0;
      req_ext[NUM_M-1:0]   = bus.m_req;
      sel                  = ID_W'(rr_pick(req_ext, 32'(ptr), NUM_M));
   end

   // full uses the registered count, so a pop never frees a slot in the same cycle
   assign bus.s_req = (|bus.m_req) & ~full;
   assign hs        = bus.s_req & bus.s_gnt;
   assign pop       = bus.s_rvalid & ~empty;

   always_comb begin
      bus.s_addr   = '0;
      bus.s_we     = 1'b0;
      bus.s_be     = '0;
      bus.s_wdata  = '0;
      bus.m_gnt    = '0;
      bus.m_rvalid = '0;
      bus.m_err    = '0;
      bus.m_rdata  = '0;
      if (bus.s_req) begin
         bus.s_addr  = bus.m_addr[sel*ADDR_W +: ADDR_W];
         bus.s_we    = bus.m_we[sel];
         bus.s_be    = bus.m_be[sel*BE_W +: BE_W];
         bus.s_wdata = bus.m_wdata[sel*DATA_W +: DATA_W];
      end
      if (hs) bus.m_gnt[sel] = 1'b1;
      if (pop) begin
         bus.m_rvalid[head] = 1'b1;
         bus.m_err[head]    = bus.s_err;
         bus.m_rdata        = bus.s_rdata;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ptr       <= '0;
         proto_err <= 1'b0;
      end else begin
         if (hs) ptr <= (sel == ID_W'(NUM_M - 1)) ? '0 : sel + 1'b1;
         if (bus.s_rvalid && empty) proto_err <= 1'b1;
      end
   end

   data_bus_id_fifo #(
      .DEPTH (MAX_OUTST),
      .W     (ID_W)
   ) u_id_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (hs),
      .din   (sel),
      .pop   (pop),
      .head  (head),
      .count (outstanding),
      .full  (full),
      .empty (empty)
   );
endmodule

// File: tb/tb_data_bus_arbiter.sv
// Directed bench for data_bus_arbiter: RR order, stall hold, outstanding limit, routing, proto_err, async reset.
module tb_data_bus_arbiter;
   localparam int NUM_M     = 2;
   localparam int ADDR_W    = 32;
   localparam int DATA_W    = 32;
   localparam int MAX_OUTST = 4;
   localparam int CNT_W     = $clog2(MAX_OUTST + 1);

   logic             clk;
   logic             rst;
   logic [CNT_W-1:0] outstanding;
   logic             proto_err;
   int               n_chk;
   int               n_err;

   data_bus_arbiter_if #(.NUM_M(NUM_M), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

   data_bus_arbiter #(
      .NUM_M(NUM_M), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_OUTST(MAX_OUTST)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .bus         (bus),
      .outstanding (outstanding),
      .proto_err   (proto_err)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // leave one time unit after the active edge, then inputs may change
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [1:0] exp_gnt [4];
      logic [1:0] exp_rv  [3];
      exp_gnt = '{2'b01, 2'b10, 2'b01, 2'b10};
      exp_rv  = '{2'b10, 2'b01, 2'b10};
      n_chk = 0;
      n_err = 0;

      rst          = 1'b1;
      bus.m_req    = '0;
      bus.m_addr   = {32'h0000_0200, 32'h0000_0100};
      bus.m_we     = 2'b10;
      bus.m_be     = {4'hC, 4'h3};
      bus.m_wdata  = {32'hBBBB_0001, 32'hAAAA_0000};
      bus.s_gnt    = 1'b0;
      bus.s_rvalid = 1'b0;
      bus.s_err    = 1'b0;
      bus.s_rdata  = '0;
      #3;
      check("rst_outstanding", 64'(outstanding), 64'd0);
      check("rst_proto_err",   64'(proto_err),   64'd0);
      check("rst_s_req",       64'(bus.s_req),   64'd0);
      check("rst_m_gnt",       64'(bus.m_gnt),   64'd0);
      check("rst_m_rvalid",    64'(bus.m_rvalid), 64'd0);
      check("rst_s_addr",      64'(bus.s_addr),  64'd0);
      step();
      step();
      rst = 1'b0;

      // Round-robin alternation with both masters requesting
      bus.m_req = 2'b11;
      bus.s_gnt = 1'b1;
      #1;
      check("rr_s_addr0", 64'(bus.s_addr),  64'h100);
      check("rr_s_we0",   64'(bus.s_we),    64'd0);
      check("rr_s_be0",   64'(bus.s_be),    64'h3);
      check("rr_wdata0",  64'(bus.s_wdata), 64'hAAAA_0000);
      for (int i = 0; i < 4; i++) begin
         check($sformatf("rr_gnt%0d", i), 64'(bus.m_gnt), 64'(exp_gnt[i]));
         if (i == 1) begin
            check("rr_s_addr1", 64'(bus.s_addr),  64'h200);
            check("rr_s_we1",   64'(bus.s_we),    64'd1);
            check("rr_s_be1",   64'(bus.s_be),    64'hC);
            check("rr_wdata1",  64'(bus.s_wdata), 64'hBBBB_0001);
         end
         step();
         #1;
      end

      // Outstanding limit reached
      check("full_outstanding", 64'(outstanding), 64'd4);
      check("full_s_req",       64'(bus.s_req),   64'd0);
      check("full_m_gnt",       64'(bus.m_gnt),   64'd0);
      check("full_s_addr",      64'(bus.s_addr),  64'd0);
      bus.s_rvalid = 1'b1;
      bus.s_rdata  = 32'h11;
      #1;
      check("full_pop_rvalid", 64'(bus.m_rvalid), 64'b01);
      check("full_pop_rdata",  64'(bus.m_rdata),  64'h11);
      check("full_bubble_req", 64'(bus.s_req),    64'd0);
      step();
      bus.s_rvalid = 1'b0;
      #1;
      check("after_pop_outstanding", 64'(outstanding), 64'd3);
      check("after_pop_s_req",       64'(bus.s_req),   64'd1);
      check("after_pop_gnt",         64'(bus.m_gnt),   64'b01);
      bus.s_gnt = 1'b0;
      bus.m_req = 2'b00;
      #1;

      // Drain remaining ids 1,0,1
      for (int i = 0; i < 3; i++) begin
         bus.s_rvalid = 1'b1;
         bus.s_rdata  = 32'(i + 32'h20);
         #1;
         check($sformatf("drain_rvalid%0d", i), 64'(bus.m_rvalid), 64'(exp_rv[i]));
         step();
      end
      bus.s_rvalid = 1'b0;
      #1;
      check("drain_outstanding", 64'(outstanding), 64'd0);

      // Single m0 grant moves ptr to 1
      bus.m_req = 2'b01;
      bus.s_gnt = 1'b1;
      #1;
      check("pre_gnt_m0", 64'(bus.m_gnt), 64'b01);
      step();
      bus.m_req = 2'b10;
      bus.s_gnt = 1'b0;

      // m1 stalled; a late m0 request must not steal the pending choice
      for (int i = 0; i < 3; i++) begin
         #1;
         check($sformatf("stall_addr%0d", i), 64'(bus.s_addr), 64'h200);
         check($sformatf("stall_gnt%0d", i),  64'(bus.m_gnt),  64'd0);
         step();
      end
      bus.m_req = 2'b11;
      #1;
      check("stall_no_rearb", 64'(bus.s_addr), 64'h200);
      step();
      bus.s_gnt = 1'b1;
      #1;
      check("stall_gnt_m1", 64'(bus.m_gnt), 64'b10);
      step();
      bus.m_req = 2'b01;
      #1;
      check("stall_gnt_m0", 64'(bus.m_gnt), 64'b01);
      step();
      bus.m_req = 2'b00;
      bus.s_gnt = 1'b0;
      #1;
      check("order_outstanding", 64'(outstanding), 64'd3);

      // Responses routed m0, m1 (with err), m0; second overlaps a new grant
      bus.s_rvalid = 1'b1;
      bus.s_rdata  = 32'hA;
      bus.s_err    = 1'b0;
      #1;
      check("resp_a_rvalid", 64'(bus.m_rvalid), 64'b01);
      check("resp_a_err",    64'(bus.m_err),    64'b00);
      check("resp_a_rdata",  64'(bus.m_rdata),  64'hA);
      step();
      bus.s_rdata = 32'hB;
      bus.s_err   = 1'b1;
      bus.m_req   = 2'b01;
      bus.s_gnt   = 1'b1;
      #1;
      check("same_pre_outstanding", 64'(outstanding), 64'd2);
      check("same_gnt",             64'(bus.m_gnt),    64'b01);
      check("resp_b_rvalid",        64'(bus.m_rvalid), 64'b10);
      check("resp_b_err",           64'(bus.m_err),    64'b10);
      check("resp_b_rdata",         64'(bus.m_rdata),  64'hB);
      step();
      bus.m_req   = 2'b00;
      bus.s_gnt   = 1'b0;
      bus.s_rdata = 32'hC;
      bus.s_err   = 1'b0;
      #1;
      check("same_post_outstanding", 64'(outstanding), 64'd2);
      check("resp_c_rvalid",         64'(bus.m_rvalid), 64'b01);
      check("resp_c_err",            64'(bus.m_err),    64'b00);
      check("resp_c_rdata",          64'(bus.m_rdata),  64'hC);
      step();
      bus.s_rdata = 32'hD;
      #1;
      check("resp_d_rvalid", 64'(bus.m_rvalid), 64'b01);
      step();
      bus.s_rvalid = 1'b0;
      #1;
      check("resp_done_outstanding", 64'(outstanding), 64'd0);

      // Unexpected response raises sticky proto_err
      bus.s_rvalid = 1'b1;
      #1;
      check("orphan_rvalid",    64'(bus.m_rvalid), 64'd0);
      check("orphan_proto_pre", 64'(proto_err),    64'd0);
      step();
      bus.s_rvalid = 1'b0;
      #1;
      check("orphan_proto_set", 64'(proto_err), 64'd1);
      step();
      check("orphan_proto_sticky", 64'(proto_err), 64'd1);

      // Async reset mid-burst
      bus.m_req = 2'b11;
      bus.s_gnt = 1'b1;
      step();
      step();
      step();
      bus.m_req = 2'b00;
      bus.s_gnt = 1'b0;
      #1;
      check("burst_outstanding", 64'(outstanding), 64'd3);
      #1;
      rst = 1'b1;
      #1;
      check("async_rst_outstanding", 64'(outstanding), 64'd0);
      check("async_rst_proto_err",   64'(proto_err),   64'd0);
      step();
      rst       = 1'b0;
      bus.m_req = 2'b11;
      #1;
      check("post_rst_ptr0", 64'(bus.s_addr), 64'h100);
      bus.m_req    = 2'b00;
      bus.s_rvalid = 1'b1;
      #1;
      check("late_resp_rvalid", 64'(bus.m_rvalid), 64'd0);
      step();
      bus.s_rvalid = 1'b0;
      #1;
      check("late_resp_proto", 64'(proto_err), 64'd1);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
